// File: rtl/sm2201_isa_camac_bridge_if.sv
// ISA / CAMAC side-band bundle for the SM2201 bridge.
// The tristate data buses stay plain inout ports on the bridge.
interface sm2201_isa_camac_bridge_if #(
    parameter int CB_ADDR_WIDTH = 5
);
    logic [9:0]               isa_addr;
    logic                     isa_ale;
    logic                     isa_aen;
    logic                     isa_ior;
    logic                     isa_iow;
    logic                     isa_chrdy;
    logic [7:0]               isa_irq;
    logic [CB_ADDR_WIDTH-1:0] cb_addr;
    logic                     cb_rd;
    logic                     cb_wr;
    logic                     cb_prr;
    logic                     cb_zk4;

    modport slave (
        input  isa_addr, isa_ale, isa_aen, isa_ior, isa_iow,
        input  cb_prr, cb_zk4,
        output isa_chrdy, isa_irq, cb_addr, cb_rd, cb_wr
    );

    modport master (
        output isa_addr, isa_ale, isa_aen, isa_ior, isa_iow,
        output cb_prr, cb_zk4,
        input  isa_chrdy, isa_irq, cb_addr, cb_rd, cb_wr
    );
endinterface

// File: rtl/sm2201_isa_camac_bridge.sv
// ISA-to-CAMAC bridge: byte-split register window, chrdy stretching,
// CAMAC timeout and LAM-to-IRQ routing.
module sm2201_isa_camac_bridge #(
    parameter logic [9:0] BASE_ADDR     = 10'h110,
    parameter int         NUM_REGS      = 4,
    parameter int         CB_ADDR_WIDTH = 5,
    parameter int         WAIT_STATES   = 2,
    parameter int         TIMEOUT       = 64,
    parameter int         IRQ_INDEX     = 3
) (
    input  logic                          isa_clk,
    input  logic                          isa_reset,
    sm2201_isa_camac_bridge_if.slave      bus,
    inout  wire  [7:0]                    isa_data,
    inout  wire  [15:0]                   cb_data
);

    localparam logic [9:0] STAT_OFF = 10'(2 * NUM_REGS);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_MIN =
        CW'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, RECOVER} state_t;

    state_t                   state_q;
    logic [9:0]               addr_q;
    logic [2:0]               ior_q;
    logic [2:0]               iow_q;
    logic [2:0]               zk_q;
    logic [1:0]               prr_q;
    logic [CW-1:0]            cnt_q;
    logic                     rd_op_q;
    logic                     chrdy_q;
    logic                     cb_rd_q;
    logic                     cb_wr_q;
    logic [CB_ADDR_WIDTH-1:0] cb_addr_q;
    logic [7:0]               wr_hi_q;
    logic [7:0]               wr_hold_q;
    logic [15:0]              rd_word_q;
    logic                     irq_en_q;
    logic                     lam_q;
    logic                     tmo_q;

    logic [9:0] off;
    logic       hit;
    logic       is_stat;
    logic       ior_fall;
    logic       iow_fall;
    logic       lam_set;
    logic       start_cam;
    logic [7:0] rd_byte;

    assign off       = addr_q - BASE_ADDR;
    assign hit       = ~bus.isa_aen & (off <= STAT_OFF);
    assign is_stat   = (off == STAT_OFF);
    assign ior_fall  = ~ior_q[1] & ior_q[2];
    assign iow_fall  = ~iow_q[1] & iow_q[2];
    assign lam_set   = ~zk_q[1] & zk_q[2];
    // Low-byte reads and high-byte writes are the only CAMAC cycles.
    assign start_cam = hit & ~is_stat & (ior_fall ? ~off[0] : off[0]);

    assign rd_byte = is_stat ? {5'b0, tmo_q, lam_q, irq_en_q}
                   : off[0]  ? rd_word_q[15:8]
                   :           rd_word_q[7:0];

    assign isa_data = (~bus.isa_ior & hit) ? rd_byte : 8'bz;
    assign cb_data  = cb_wr_q ? {wr_hi_q, wr_hold_q} : 16'bz;

    assign bus.isa_chrdy = chrdy_q;
    assign bus.cb_rd     = cb_rd_q;
    assign bus.cb_wr     = cb_wr_q;
    assign bus.cb_addr   = cb_addr_q;
    assign bus.isa_irq   = (irq_en_q & lam_q) ? 8'(1 << IRQ_INDEX) : 8'h00;

    // Address latch: transparent while ALE is high.
    always_ff @(posedge isa_clk or posedge isa_reset) begin
        if (isa_reset) addr_q <= '0;
        else if (bus.isa_ale) addr_q <= bus.isa_addr;
    end

    // Two-flop synchronisers plus one delayed stage for edge detection.
    always_ff @(posedge isa_clk or posedge isa_reset) begin
        if (isa_reset) begin
            ior_q <= 3'b111;
            iow_q <= 3'b111;
            zk_q  <= 3'b111;
            prr_q <= 2'b11;
        end else begin
            ior_q <= {ior_q[1:0], bus.isa_ior};
            iow_q <= {iow_q[1:0], bus.isa_iow};
            zk_q  <= {zk_q[1:0], bus.cb_zk4};
            prr_q <= {prr_q[0], bus.cb_prr};
        end
    end

    // Bus-cycle FSM with registered CAMAC strobes, chrdy and status bits.
    always_ff @(posedge isa_clk or posedge isa_reset) begin
        if (isa_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_op_q   <= 1'b0;
            chrdy_q   <= 1'b1;
            cb_rd_q   <= 1'b0;
            cb_wr_q   <= 1'b0;
            cb_addr_q <= '0;
            wr_hi_q   <= '0;
            wr_hold_q <= '0;
            rd_word_q <= '0;
            irq_en_q  <= 1'b0;
            lam_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ior_fall | iow_fall) begin
                        rd_op_q <= ior_fall;
                        state_q <= DONE;
                        unique case (1'b1)
                            start_cam: begin
                                state_q   <= ACCESS;
                                cnt_q     <= '0;
                                chrdy_q   <= 1'b0;
                                cb_addr_q <= off[CB_ADDR_WIDTH:1];
                                cb_rd_q   <= ior_fall;
                                cb_wr_q   <= ~ior_fall;
                                wr_hi_q   <= isa_data;
                            end
                            (hit & is_stat & ~ior_fall): begin
                                irq_en_q <= isa_data[0];
                                if (isa_data[1]) lam_q <= 1'b0;
                                if (isa_data[2]) tmo_q <= 1'b0;
                            end
                            (hit & ~is_stat & ~ior_fall & ~off[0]): begin
                                wr_hold_q <= isa_data;
                            end
                            default: ;
                        endcase
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (!prr_q[1] && cnt_q >= CNT_MIN) begin
                        state_q <= DONE;
                        chrdy_q <= 1'b1;
                        cb_rd_q <= 1'b0;
                        cb_wr_q <= 1'b0;
                        if (rd_op_q) rd_word_q <= cb_data;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= DONE;
                        chrdy_q <= 1'b1;
                        cb_rd_q <= 1'b0;
                        cb_wr_q <= 1'b0;
                        tmo_q   <= 1'b1;
                        if (rd_op_q) rd_word_q <= 16'hFFFF;
                    end
                end
                DONE: begin
                    if (rd_op_q ? ior_q[1] : iow_q[1]) state_q <= RECOVER;
                end
                RECOVER: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            // A LAM edge outranks a simultaneous clear from a status write.
            if (lam_set) lam_q <= 1'b1;
        end
    end

endmodule
